// File: rtl/hamm_fifo_rcv_if.sv
// Bus between the Hamming encoder stage, the receive FIFO/decoder and the
// serializer. The receiver uses the slave modport. The bench or upstream
// logic uses the master modport.
interface hamm_fifo_rcv_if;
   logic [37:0] data_ham_in;
   logic        start_write;
   logic        read_signal;
   logic [31:0] data_output;
   logic        data_valid;
   logic        err_corrected;
   logic        err_uncorrectable;
   logic        fifo_full;
   logic        fifo_empty;
   logic        overflow;

   modport master (
      output data_ham_in, start_write, read_signal,
      input  data_output, data_valid, err_corrected, err_uncorrectable,
             fifo_full, fifo_empty, overflow
   );

   modport slave (
      input  data_ham_in, start_write, read_signal,
      output data_output, data_valid, err_corrected, err_uncorrectable,
             fifo_full, fifo_empty, overflow
   );
endinterface

// File: rtl/hamm_fifo_rcv.sv
// hamm_fifo_rcv: a FIFO that stores 38-bit Hamming codewords, followed by a
// SEC decoder on the read side.
// - Bit index = Hamming position - 1. Parity bits sit at positions 1,2,4,8,16,32.
// - The decoded word and its error flags are registered. They appear one cycle
//   after the accepted read, and they hold their values until the next pulse.
// - Optional feature: when HAMM_ERR_CNT_EN is defined, the block adds a
//   saturating 16-bit counter of corrected words on port err_count.
module hamm_fifo_rcv #(
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3
) (
   input  logic                  CLK,
   input  logic                  reset,
   hamm_fifo_rcv_if.slave        bus
`ifdef HAMM_ERR_CNT_EN
   ,
   output logic [15:0]           err_count
`endif
);

   localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

   // Storage and pointers
   logic [37:0]       r_mem [DEPTH];
   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W-1:0] r_rd_ptr;
   logic [ADDR_W:0]   r_count;
   logic              r_full;
   logic              r_empty;
   logic              r_overflow;

   // Registered decoder results
   logic [31:0]       r_data;
   logic              r_data_valid;
   logic              r_err_corr;
   logic              r_err_unc;

   // Handshake qualification
   logic              w_rd_ok;
   logic              w_wr_ok;
   logic [ADDR_W:0]   w_count_nxt;

   // Decoder datapath
   logic [37:0]       w_cw;
   logic [37:0]       w_cw_fix;
   logic [5:0]        w_syn;
   logic              w_corr;
   logic              w_unc;
   logic [31:0]       w_data;

   // A read is taken only when data is present. Reading an empty FIFO does not
   // fall through, even when a write arrives in the same cycle. When the FIFO is
   // full, a write is accepted only if a read frees a slot in the same cycle.
   assign w_rd_ok = bus.read_signal & ~r_empty;
   assign w_wr_ok = bus.start_write & (~r_full | w_rd_ok);

   // Occupancy for the next cycle: a write alone adds one, a read alone
   // subtracts one, and both together leave it unchanged
   always_comb begin
      // NOTE: assign every always_comb output a default first so that a path
      // that does not assign it cannot infer a latch.
      w_count_nxt = r_count;
      case ({w_wr_ok, w_rd_ok})
         2'b10:   w_count_nxt = r_count + 1'b1;
         2'b01:   w_count_nxt = r_count - 1'b1;
         default: w_count_nxt = r_count;
      endcase
   end

   // Codeword storage, written on an accepted write
   // NOTE: the array is not reset. The pointers and occupancy alone decide
   // which entries are valid. Leaving the array unreset lets it map to RAM.
   always_ff @(posedge CLK) begin
      if (w_wr_ok)
         r_mem[r_wr_ptr] <= bus.data_ham_in;
   end

   // Pointers, occupancy, registered full/empty flags and the sticky overflow flag
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_full     <= 1'b0;
         r_empty    <= 1'b1;
         r_overflow <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments. Every flop
         // then samples values from before the edge, whatever the statement order.
         if (w_wr_ok)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_rd_ok)
            r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= w_count_nxt;
         r_full  <= (w_count_nxt == FULL_COUNT);
         r_empty <= (w_count_nxt == '0);
         if (bus.start_write && !w_wr_ok)
            r_overflow <= 1'b1;
      end
   end

   // Syndrome of the entry at the head of the FIFO, then single-bit correction
   always_comb begin
      w_cw  = r_mem[r_rd_ptr];
      w_syn = '0;
      for (int i = 0; i < 38; i++) begin
         if (w_cw[i])
            w_syn = w_syn ^ 6'(i + 1);
      end
      w_cw_fix = w_cw;
      w_corr   = 1'b0;
      w_unc    = 1'b0;
      if (w_syn > 6'd38) begin
         w_unc = 1'b1;
      end else if (w_syn != 6'd0) begin
         w_cw_fix[w_syn - 6'd1] = ~w_cw[w_syn - 6'd1];
         w_corr                 = 1'b1;
      end
   end

   // Take the 32 data bits from the non-power-of-two positions, low to high
   assign w_data = {w_cw_fix[37:32], w_cw_fix[30:16], w_cw_fix[14:8],
                    w_cw_fix[6:4],   w_cw_fix[2]};

   // Register the decode result on each accepted read. Between reads the
   // result holds its value.
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         r_data       <= '0;
         r_data_valid <= 1'b0;
         r_err_corr   <= 1'b0;
         r_err_unc    <= 1'b0;
      end else begin
         r_data_valid <= w_rd_ok;
         if (w_rd_ok) begin
            r_data     <= w_data;
            r_err_corr <= w_corr;
            r_err_unc  <= w_unc;
         end
      end
   end

`ifdef HAMM_ERR_CNT_EN
   logic [15:0] r_err_count;

   // Saturating count of corrected words. It updates on the same edge as the
   // data_valid pulse that reports the word.
   always_ff @(posedge CLK or posedge reset) begin
      if (reset)
         r_err_count <= '0;
      else if (w_rd_ok && w_corr && (r_err_count != 16'hFFFF))
         r_err_count <= r_err_count + 16'd1;
   end

   assign err_count = r_err_count;
`endif

   assign bus.data_output       = r_data;
   assign bus.data_valid        = r_data_valid;
   assign bus.err_corrected     = r_err_corr;
   assign bus.err_uncorrectable = r_err_unc;
   assign bus.fifo_full         = r_full;
   assign bus.fifo_empty        = r_empty;
   assign bus.overflow          = r_overflow;

endmodule

// File: tb/tb_hamm_fifo_rcv.sv
// Self-checking bench for hamm_fifo_rcv: directed cases followed by a
// randomized phase. All expectations come from a queue-based reference model
// with a positional Hamming encoder and decoder.
// Define HAMM_ERR_CNT_EN to also check the optional err_count port.
module tb_hamm_fifo_rcv;

   localparam int DEPTH = 8;

   logic CLK;
   logic reset;
   hamm_fifo_rcv_if bus();

`ifdef HAMM_ERR_CNT_EN
   logic [15:0] err_count;
`endif

   hamm_fifo_rcv #(.DEPTH(DEPTH), .ADDR_W(3)) dut (
      .CLK       (CLK),
      .reset     (reset),
      .bus       (bus)
`ifdef HAMM_ERR_CNT_EN
      ,
      .err_count (err_count)
`endif
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [37:0] q[$];
   logic        m_ovf;
   logic [31:0] m_data;
   logic        m_corr;
   logic        m_unc;
   int          m_errcnt;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit is_pow2(input int p);
      return (p & (p - 1)) == 0;
   endfunction

   function automatic logic [5:0] syndrome(input logic [37:0] w);
      int s = 0;
      for (int p = 1; p <= 38; p++)
         if (w[p-1]) s = s ^ p;
      return 6'(s);
   endfunction

   function automatic logic [37:0] encode(input logic [31:0] d);
      logic [37:0] w = '0;
      logic [5:0]  s;
      int j = 0;
      for (int p = 1; p <= 38; p++) begin
         if (!is_pow2(p)) begin
            w[p-1] = d[j];
            j++;
         end
      end
      s = syndrome(w);
      for (int k = 0; k < 6; k++)
         w[(1 << k) - 1] = s[k];
      return w;
   endfunction

   task automatic decode(input logic [37:0] cw, output logic [31:0] d,
                         output logic c, output logic u);
      logic [37:0] w = cw;
      int s = int'(syndrome(cw));
      int j = 0;
      c = 1'b0;
      u = 1'b0;
      if (s >= 39) u = 1'b1;
      else if (s >= 1) begin
         w[s-1] = ~w[s-1];
         c = 1'b1;
      end
      d = '0;
      for (int p = 1; p <= 38; p++) begin
         if (!is_pow2(p)) begin
            d[j] = w[p-1];
            j++;
         end
      end
   endtask

   task automatic model_clear();
      q.delete();
      m_ovf    = 1'b0;
      m_data   = '0;
      m_corr   = 1'b0;
      m_unc    = 1'b0;
      m_errcnt = 0;
   endtask

   task automatic check_all(input logic exp_valid);
      check("data_valid", 32'(bus.data_valid), 32'(exp_valid));
      check("data_output", bus.data_output, m_data);
      check("err_corrected", 32'(bus.err_corrected), 32'(m_corr));
      check("err_uncorrectable", 32'(bus.err_uncorrectable), 32'(m_unc));
      check("fifo_full", 32'(bus.fifo_full), 32'(q.size() == DEPTH));
      check("fifo_empty", 32'(bus.fifo_empty), 32'(q.size() == 0));
      check("overflow", 32'(bus.overflow), 32'(m_ovf));
`ifdef HAMM_ERR_CNT_EN
      check("err_count", 32'(err_count), 32'(m_errcnt));
`endif
   endtask

   // One clock cycle. Inputs are driven 1 time unit after the previous edge.
   // Outputs are checked 1 time unit after this edge.
   task automatic step(input logic wr, input logic rd, input logic [37:0] cw);
      logic rd_ok, wr_ok;
      bus.start_write = wr;
      bus.read_signal = rd;
      bus.data_ham_in = cw;
      rd_ok = rd && (q.size() != 0);
      wr_ok = wr && ((q.size() < DEPTH) || rd_ok);
      if (wr && !wr_ok) m_ovf = 1'b1;
      if (rd_ok) begin
         decode(q.pop_front(), m_data, m_corr, m_unc);
         if (m_corr && m_errcnt < 16'hFFFF) m_errcnt++;
      end
      if (wr_ok) q.push_back(cw);
      @(posedge CLK);
      #1;
      bus.start_write = 1'b0;
      bus.read_signal = 1'b0;
      check_all(rd_ok);
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      model_clear();
      @(posedge CLK);
      #1;
      check_all(1'b0);
      reset = 1'b0;
   endtask

   initial begin
      logic [37:0] cw;
      reset           = 1'b1;
      bus.start_write = 1'b0;
      bus.read_signal = 1'b0;
      bus.data_ham_in = '0;
      model_clear();
      #1;
      check_all(1'b0);
      apply_reset();

      // Clean word
      step(1, 0, encode(32'hDEADBEEF));
      step(0, 1, '0);
      check("clean_data", bus.data_output, 32'hDEADBEEF);
      step(0, 0, '0);

      // Single data-bit error at index 20
      cw = encode(32'h12345678);
      cw[20] = ~cw[20];
      step(1, 0, cw);
      step(0, 1, '0);
      check("single_err_data", bus.data_output, 32'h12345678);
      check("single_err_flag", 32'(bus.err_corrected), 32'd1);

      // Parity-bit error at index 31
      cw = encode(32'h0);
      cw[31] = ~cw[31];
      step(1, 0, cw);
      step(0, 1, '0);
      check("parity_err_data", bus.data_output, 32'h0);

      // Double error that gives syndrome 32^7 = 39, which is out of range
      cw = encode(32'hA5A5_0F0F);
      cw[31] = ~cw[31];
      cw[6]  = ~cw[6];
      step(1, 0, cw);
      step(0, 1, '0);
      check("uncorr_flag", 32'(bus.err_uncorrectable), 32'd1);

      // Nine writes with no reads: the ninth is dropped, then eight words drain in order
      for (int i = 1; i <= 9; i++)
         step(1, 0, encode(32'(i)));
      check("ovf_set", 32'(bus.overflow), 32'd1);
      for (int i = 1; i <= 8; i++) begin
         step(0, 1, '0);
         check("drain_order", bus.data_output, 32'(i));
      end

      // Read and write together while full, then while empty
      apply_reset();
      for (int i = 0; i < DEPTH; i++)
         step(1, 0, encode(32'(100 + i)));
      step(1, 1, encode(32'hCAFE_F00D));
      check("full_rw_ovf", 32'(bus.overflow), 32'd0);
      check("full_rw_full", 32'(bus.fifo_full), 32'd1);
      for (int i = 0; i < DEPTH; i++)
         step(0, 1, '0);
      step(1, 1, encode(32'h0BAD_BEEF));
      check("empty_rw_valid", 32'(bus.data_valid), 32'd0);
      step(0, 1, '0);
      check("empty_rw_data", bus.data_output, 32'h0BAD_BEEF);

      // Randomized traffic with 0, 1 or 2 flipped bits
      for (int n = 0; n < 300; n++) begin
         int nflip = $urandom_range(0, 2);
         cw = encode($urandom);
         for (int f = 0; f < nflip; f++) begin
            int b = $urandom_range(0, 37);
            cw[b] = ~cw[b];
         end
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), cw);
      end

      // Reset during a read discards stored words and the in-flight decode
      apply_reset();
      for (int i = 0; i < 3; i++)
         step(1, 0, encode(32'(200 + i)));
      bus.read_signal = 1'b1;
      reset = 1'b1;
      model_clear();
      @(posedge CLK);
      #1;
      bus.read_signal = 1'b0;
      check_all(1'b0);
      reset = 1'b0;
      step(1, 0, encode(32'h7777_1234));
      step(0, 1, '0);
      check("post_reset_data", bus.data_output, 32'h7777_1234);
      step(0, 0, '0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
